instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/mips_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/instr_fetch.sv | 149 ++++++++++++++
 tb/tb_instr_fetch.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch front end.
//   fetch_state_e : instruction fetch FSM states (IDLE/WAIT/DROP)
//   INSTR_WIDTH   : instruction word width
//   NOP           : instruction presented when nothing is buffered
package mips_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer for fetched {instruction, pc} entries.
//   clk, rst_n : clock, async active-low reset
//   push/wdata : write an entry at the tail
//   pop        : remove the head entry
//   flush      : empty the buffer (overrides push/pop)
//   head       : current head entry
//   count      : number of valid entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one word request at a time to instruction
// memory, buffers responses in fetch_fifo and presents them to decode.
//   clk, rst_n          : clock, async active-low reset
//   imem_req/imem_addr  : registered fetch request and word address
//   imem_ack/imem_rdata : memory response (ends the request)
//   redirect_valid/_pc  : branch/jump redirect, flushes the buffer
//   inst_valid/_ready   : handshake to the decode stage
//   instruction/inst_pc : buffer head (NOP / 0 when empty)
//   fetch_count         : accepted-instruction counter, present only when
//                         INSTR_FETCH_PERF_CNT_EN is defined
module instr_fetch
  import mips_pkg::*;
#(
  parameter int unsigned          PC_WIDTH   = 8,
  parameter int unsigned          FIFO_DEPTH = 2,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]    inst_pc
`ifdef INSTR_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            fetch_count
`endif
);

  localparam int unsigned EW = INSTR_WIDTH + PC_WIDTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic                req_q, req_d;

  logic                push, pop, flush, empty;
  logic [EW-1:0]       head;
  logic [CW-1:0]       count;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({imem_rdata, pc_q}),
    .head  (head),
    .count (count)
  );

  assign empty       = (count == '0);
  assign flush       = redirect_valid;
  assign inst_valid  = !empty && !redirect_valid;
  assign pop         = inst_valid && inst_ready;
  assign instruction = empty ? NOP : head[EW-1:PC_WIDTH];
  assign inst_pc     = empty ? '0  : head[PC_WIDTH-1:0];

  // Issuing only while count < depth reserves the slot the response will
  // land in; with one request outstanding the push can never overflow.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    push    = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end
    case (state_q)
      IDLE: begin
        if (!redirect_valid && (count < CW'(FIFO_DEPTH))) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (!redirect_valid) begin
            push = 1'b1;
            pc_d = pc_q + PC_WIDTH'(1);
          end
        end else if (redirect_valid) begin
          state_d = DROP;
        end
      end
      DROP: begin
        // Request stays up on the old address; its response is discarded.
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (pop) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch (default parameters).
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [7:0]  inst_pc;
`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .inst_pc        (inst_pc)
`ifdef INSTR_FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat_fixed = 1;           // 0 selects a random ack latency 1..3

  int         rise_cyc[$];     // cycle in which each new request appeared
  logic [7:0] rise_addr[$];
  logic [7:0] acc_pc[$];       // pcs of accepted instructions since reset
  int         accepted;
  logic [7:0] exp_pc;          // next pc the decode stage should receive

  always @(posedge clk) cyc++;

  function automatic logic [31:0] word(input logic [7:0] a);
    return {16'h4001 + {8'h00, a}, 8'h00, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req_after(input int rc, output logic [7:0] a, output int c);
    bit found = 1'b0;
    a = '0;
    c = rc;
    for (int k = 0; k < 80 && !found; k++) begin
      foreach (rise_cyc[i]) begin
        if (!found && rise_cyc[i] > rc) begin
          found = 1'b1;
          a = rise_addr[i];
          c = rise_cyc[i];
        end
      end
      if (!found) tick();
    end
    check("req_wait_bound", {31'd0, found}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'd0, imem_req},   32'd0);
    check({tag, "_addr"},  {24'd0, imem_addr},  32'd0);
    check({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
    check({tag, "_instr"}, instruction,         32'd0);
    check({tag, "_pc"},    {24'd0, inst_pc},    32'd0);
`ifdef INSTR_FETCH_PERF_CNT_EN
    check({tag, "_fcnt"},  fetch_count,         32'd0);
`endif
  endtask

  // Memory model: ack after a per-request latency, data derived from address.
  initial begin : mem_model
    int cnt;
    int lat;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    cnt = 0;
    lat = 1;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !imem_req) begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        cnt = 0;
        lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 3));
      end else begin
        cnt++;
        if (cnt >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = word(imem_addr);
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = $urandom;
        end
      end
    end
  end

  // Reference: the decode stage sees a contiguous pc stream that restarts
  // at each redirect target; every word must match the memory contents.
  initial begin : monitor
    logic       prev_req;
    logic       prev_ack;
    logic [7:0] prev_addr;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    exp_pc = 8'h00; accepted = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0; prev_ack = 1'b0;
        exp_pc = 8'h00; accepted = 0;
        rise_cyc.delete(); rise_addr.delete(); acc_pc.delete();
      end else begin
        if (imem_req && !prev_req) begin
          rise_cyc.push_back(cyc);
          rise_addr.push_back(imem_addr);
        end
        if (imem_req && prev_req && !prev_ack)
          check("addr_stable", {24'd0, imem_addr}, {24'd0, prev_addr});
        if (redirect_valid) begin
          check("valid_during_redirect", {31'd0, inst_valid}, 32'd0);
          exp_pc = redirect_pc;
        end else if (inst_valid && inst_ready) begin
          check("deliver_pc", {24'd0, inst_pc}, {24'd0, exp_pc});
          check("deliver_word", instruction, word(exp_pc));
          acc_pc.push_back(inst_pc);
          accepted++;
          exp_pc++;
        end else if (!inst_valid) begin
          check("nop_when_empty", instruction, 32'd0);
        end
        prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] a;
    logic [7:0] old_addr;
    logic [7:0] r;
    int c, c2, rc, acc0;

    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    lat_fixed = 1;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");

    // Basic stream, 1-cycle ack latency, decode always ready.
    tick();
    rst_n = 1'b1; inst_ready = 1'b1;
    @(negedge clk); check("req_before_edge", {31'd0, imem_req}, 32'd0);
    @(negedge clk); check("first_req", {31'd0, imem_req}, 32'd1);
                    check("first_addr", {24'd0, imem_addr}, 32'd0);
                    check("valid_before_ack", {31'd0, inst_valid}, 32'd0);
    @(negedge clk); check("valid_pc0", {31'd0, inst_valid}, 32'd1);
                    check("pc0", {24'd0, inst_pc}, 32'd0);
                    check("word0", instruction, 32'h40010000);
    @(negedge clk); check("req1", {31'd0, imem_req}, 32'd1);
                    check("addr1", {24'd0, imem_addr}, 32'd1);
    @(negedge clk); check("valid_pc1", {31'd0, inst_valid}, 32'd1);
                    check("pc1", {24'd0, inst_pc}, 32'd1);
                    check("word1", instruction, 32'h40020001);
    repeat (4) tick();
    check("req_count_stream", {31'd0, rise_addr.size() >= 3}, 32'd1);
    for (int i = 0; i < 3; i++)
      if (i < rise_addr.size()) check("req_order", {24'd0, rise_addr[i]}, i);

    // Back-pressure: buffer fills, requests stop, nothing lost.
    rst_n = 1'b0; inst_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("req_count_stall", rise_addr.size(), 32'd2);
    check("req_idle_stall", {31'd0, imem_req}, 32'd0);
    check("valid_stall", {31'd0, inst_valid}, 32'd1);
    check("pc_stall", {24'd0, inst_pc}, 32'd0);
    inst_ready = 1'b1;
    for (int k = 0; k < 40 && accepted < 3; k++) tick();
    check("deliver_count_stall", {31'd0, accepted >= 3}, 32'd1);
    for (int i = 0; i < 3; i++)
      if (i < acc_pc.size()) check("deliver_order", {24'd0, acc_pc[i]}, i);

    // Redirect while waiting on a slow ack: DROP, then fetch at target.
    lat_fixed = 3;
    for (int k = 0; k < 40 && !(imem_req && !imem_ack); k++) tick();
    old_addr = imem_addr;
    redirect_valid = 1'b1; redirect_pc = 8'h20; rc = cyc;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("drop_holds_req", {31'd0, imem_req}, 32'd1);
    check("drop_holds_addr", {24'd0, imem_addr}, {24'd0, old_addr});
    wait_req_after(rc, a, c);
    check("addr_after_drop", {24'd0, a}, 32'h20);
    acc0 = accepted;
    for (int k = 0; k < 40 && accepted == acc0; k++) tick();
    check("first_after_drop", {24'd0, acc_pc[acc_pc.size()-1]}, 32'h20);

    // Redirect coincident with ack and with a pop.
    lat_fixed = 1; inst_ready = 1'b0;
    for (int k = 0; k < 40 && !(imem_ack && inst_valid); k++) tick();
    r = 8'h40 + 8'($urandom_range(0, 63));
    redirect_valid = 1'b1; redirect_pc = r; inst_ready = 1'b1; rc = cyc;
    @(negedge clk);
    check("valid_on_redirect_ack", {31'd0, inst_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    check("flushed_after_redirect", {31'd0, inst_valid}, 32'd0);
    check("req_dropped_after_redirect", {31'd0, imem_req}, 32'd0);
    wait_req_after(rc, a, c);
    check("addr_after_redirect_ack", {24'd0, a}, {24'd0, r});

    // Random traffic against the stream model.
    lat_fixed = 0;
    acc0 = accepted;
    for (int k = 0; k < 300; k++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1; redirect_pc = 8'($urandom);
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
    end
    redirect_valid = 1'b0; inst_ready = 1'b1;
    check("random_progress", {31'd0, accepted > acc0}, 32'd1);

    // pc wrap from 8'hFF to 8'h00.
    redirect_valid = 1'b1; redirect_pc = 8'hFF; rc = cyc;
    tick();
    redirect_valid = 1'b0;
    wait_req_after(rc, a, c);
    check("wrap_addr_ff", {24'd0, a}, 32'hFF);
    wait_req_after(c, a, c2);
    check("wrap_addr_00", {24'd0, a}, 32'h00);

    // Five accepted instructions around one redirect.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; inst_ready = 1'b1;
    for (int k = 0; k < 60 && accepted < 3; k++) tick();
    redirect_valid = 1'b1; redirect_pc = 8'h50;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 60 && accepted < 5; k++) tick();
    inst_ready = 1'b0;
    tick();
    check("accepted_five", accepted, 32'd5);
`ifdef INSTR_FETCH_PERF_CNT_EN
    check("fetch_count_five", fetch_count, 32'd5);
`endif

    // Reset pulse in the middle of a request.
    lat_fixed = 3; inst_ready = 1'b1;
    for (int k = 0; k < 40 && !(imem_req && !imem_ack); k++) tick();
    check("req_before_midreset", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick();
    lat_fixed = 1;
    rst_n = 1'b1;
    @(negedge clk); check("req_after_midreset_edge0", {31'd0, imem_req}, 32'd0);
    @(negedge clk); check("req_after_midreset", {31'd0, imem_req}, 32'd1);
                    check("addr_after_midreset", {24'd0, imem_addr}, 32'd0);
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
